// File: rtl/uart_rx_packet_decoder.sv
// Recovers SOF|LEN|payload|CHK frames from a UART byte stream and streams good payloads out.
// Optional feature: define UART_PKT_TIMEOUT_EN to abort frames stalled mid-reception.
module uart_rx_packet_decoder #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = 8'h7E,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_ERR,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  output logic       OUT_LAST,
  input  logic       OUT_READY,
  output logic       BUSY,
  output logic       RX_DROP,
  output logic       PKT_OK,
  output logic       PKT_ERR,
  output logic [1:0] ERR_CODE
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0] ERR_CHK   = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_RX    = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  if (MAX_LEN < 2 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("uart_rx_packet_decoder: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t           state;
  logic [7:0]       pkt_buf [MAX_LEN];
  logic [IDX_W-1:0] len_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_nxt;
  logic [7:0]       chk_acc;
  logic             in_frame;
  logic             tmo_hit;

  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= MAX_LEN_B);
  endfunction

  assign rd_nxt   = rd_idx + 1'b1;
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = in_frame && !RX_VALID && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Every state entry happens on an RX_VALID or lands in IDLE, so those cases cover "clear on entry".
  always_ff @(posedge PCLK) begin
    if (PRESET || RX_VALID || !in_frame || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Payload storage is plain data and is never reset.
  always_ff @(posedge PCLK) begin
    if (state == S_PAYLOAD && RX_VALID) begin
      pkt_buf[wr_idx] <= RX_DATA;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= S_IDLE;
      len_m1    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      chk_acc   <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      BUSY      <= 1'b0;
      RX_DROP   <= 1'b0;
      PKT_OK    <= 1'b0;
      PKT_ERR   <= 1'b0;
      ERR_CODE  <= '0;
    end else begin
      PKT_OK  <= 1'b0;
      PKT_ERR <= 1'b0;
      RX_DROP <= 1'b0;
      if (tmo_hit) begin
        PKT_ERR  <= 1'b1;
        ERR_CODE <= ERR_TMO;
        state    <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (RX_VALID && !RX_ERR && RX_DATA == SOF_BYTE) state <= S_LEN;
          end
          S_LEN: begin
            if (RX_VALID) begin
              if (RX_ERR || !len_ok(RX_DATA)) begin
                PKT_ERR  <= 1'b1;
                ERR_CODE <= RX_ERR ? ERR_RX : ERR_LEN;
                state    <= S_IDLE;
              end else begin
                len_m1  <= IDX_W'(RX_DATA - 8'd1);
                chk_acc <= RX_DATA;
                wr_idx  <= '0;
                state   <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (RX_VALID) begin
              if (RX_ERR) begin
                PKT_ERR  <= 1'b1;
                ERR_CODE <= ERR_RX;
                state    <= S_IDLE;
              end else begin
                chk_acc <= chk_acc ^ RX_DATA;
                if (wr_idx == len_m1) state <= S_CHK;
                else                  wr_idx <= wr_idx + 1'b1;
              end
            end
          end
          S_CHK: begin
            if (RX_VALID) begin
              if (RX_ERR || RX_DATA != chk_acc) begin
                PKT_ERR  <= 1'b1;
                ERR_CODE <= RX_ERR ? ERR_RX : ERR_CHK;
                state    <= S_IDLE;
              end else begin
                // First payload byte is presented together with the PKT_OK pulse.
                PKT_OK    <= 1'b1;
                state     <= S_DRAIN;
                rd_idx    <= '0;
                OUT_DATA  <= pkt_buf[0];
                OUT_LAST  <= (len_m1 == '0);
                OUT_VALID <= 1'b1;
                BUSY      <= 1'b1;
              end
            end
          end
          S_DRAIN: begin
            RX_DROP <= RX_VALID;
            if (OUT_READY) begin
              if (OUT_LAST) begin
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
                BUSY      <= 1'b0;
                state     <= S_IDLE;
              end else begin
                rd_idx   <= rd_nxt;
                OUT_DATA <= pkt_buf[rd_nxt];
                OUT_LAST <= (rd_nxt == len_m1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_decoder.sv
// Randomized bench for uart_rx_packet_decoder against a queue-based frame model.
module tb_uart_rx_packet_decoder;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'h7E;
  localparam int         TMO     = 100;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ERR;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_LAST;
  logic       OUT_READY;
  logic       BUSY;
  logic       RX_DROP;
  logic       PKT_OK;
  logic       PKT_ERR;
  logic [1:0] ERR_CODE;

  uart_rx_packet_decoder #(
    .MAX_LEN        (MAX_LEN),
    .SOF_BYTE       (SOF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_ERR    (RX_ERR),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_LAST  (OUT_LAST),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY),
    .RX_DROP   (RX_DROP),
    .PKT_OK    (PKT_OK),
    .PKT_ERR   (PKT_ERR),
    .ERR_CODE  (ERR_CODE)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus: {err, byte}; model: current frame bytes, expected drain bytes, pending pulses.
  logic [8:0] stim_q[$];
  logic [7:0] cur[$];
  logic [7:0] dq[$];
  bit         in_frame;
  bit         exp_ok, exp_err, exp_drop;
  logic [1:0] exp_code;
  int         tcnt;
  int         ready_mode;  // 0 random, 1 always ready, 2 stalled
  int         gap_pct;

  function automatic void pkt_abort(input logic [1:0] code);
    exp_err  = 1'b1;
    exp_code = code;
    in_frame = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic e);
    logic [7:0] x;
    if (!in_frame) begin
      if (!e && b == SOF) begin
        in_frame = 1'b1;
        cur.delete();
      end
      return;
    end
    if (e) begin
      pkt_abort(2'd2);
      return;
    end
    cur.push_back(b);
    if (cur.size() == 1) begin
      if (b == 8'd0 || int'(b) > MAX_LEN) pkt_abort(2'd1);
    end else if (cur.size() == int'(cur[0]) + 2) begin
      x = 8'd0;
      for (int i = 0; i <= int'(cur[0]); i++) x ^= cur[i];
      if (b == x) begin
        exp_ok = 1'b1;
        for (int i = 1; i <= int'(cur[0]); i++) dq.push_back(cur[i]);
        in_frame = 1'b0;
      end else begin
        pkt_abort(2'd0);
      end
    end
  endfunction

  task automatic push(input logic [7:0] b, input logic e);
    stim_q.push_back({e, b});
  endtask

  task automatic cycle();
    logic [8:0] w;
    bit         draining;
    @(negedge PCLK);
    check_eq("out_valid", 32'(OUT_VALID), 32'(dq.size() != 0));
    check_eq("busy", 32'(BUSY), 32'(dq.size() != 0));
    if (dq.size() != 0) begin
      check_eq("out_data", 32'(OUT_DATA), 32'(dq[0]));
      check_eq("out_last", 32'(OUT_LAST), 32'(dq.size() == 1));
    end
    check_eq("pkt_ok", 32'(PKT_OK), 32'(exp_ok));
    check_eq("pkt_err", 32'(PKT_ERR), 32'(exp_err));
    check_eq("err_code", 32'(ERR_CODE), 32'(exp_code));
    check_eq("rx_drop", 32'(RX_DROP), 32'(exp_drop));

    OUT_READY = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    if (stim_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
      w        = stim_q.pop_front();
      RX_VALID = 1'b1;
      RX_DATA  = w[7:0];
      RX_ERR   = w[8];
    end else begin
      RX_VALID = 1'b0;
      RX_DATA  = 8'($urandom);
      RX_ERR   = 1'($urandom_range(0, 1));
    end

    exp_ok   = 1'b0;
    exp_err  = 1'b0;
    exp_drop = 1'b0;
    draining = (dq.size() != 0);
    if (draining) begin
      exp_drop = RX_VALID;
      if (OUT_READY) void'(dq.pop_front());
    end else begin
`ifdef UART_PKT_TIMEOUT_EN
      if (RX_VALID || !in_frame) tcnt = 0;
      else if (tcnt == TMO - 1) begin
        pkt_abort(2'd3);
        tcnt = 0;
      end else tcnt++;
`endif
      if (RX_VALID) model_byte(RX_DATA, RX_ERR);
    end
  endtask

  task automatic run_until_idle(input int limit);
    int n = 0;
    while ((stim_q.size() != 0 || dq.size() != 0) && n < limit) begin
      cycle();
      n++;
    end
    check_eq("wait_bound", 32'(n >= limit), 32'd0);
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET    = 1'b1;
    RX_VALID  = 1'b0;
    RX_ERR    = 1'b0;
    OUT_READY = 1'b0;
    repeat (2) @(negedge PCLK);
    check_eq("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check_eq("rst_out_data", 32'(OUT_DATA), 32'd0);
    check_eq("rst_out_last", 32'(OUT_LAST), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_rx_drop", 32'(RX_DROP), 32'd0);
    check_eq("rst_pkt_ok", 32'(PKT_OK), 32'd0);
    check_eq("rst_pkt_err", 32'(PKT_ERR), 32'd0);
    check_eq("rst_err_code", 32'(ERR_CODE), 32'd0);
    PRESET   = 1'b0;
    stim_q.delete();
    cur.delete();
    dq.delete();
    in_frame = 1'b0;
    exp_ok   = 1'b0;
    exp_err  = 1'b0;
    exp_drop = 1'b0;
    exp_code = 2'd0;
    tcnt     = 0;
  endtask

  task automatic gen_frame();
    int         kind = $urandom_range(0, 6);
    int         len  = $urandom_range(1, MAX_LEN);
    int         pos;
    logic [7:0] x, b;
    case (kind)
      0, 1, 2: begin
        push(SOF, 1'b0);
        push(8'(len), 1'b0);
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = ($urandom_range(0, 7) == 0) ? SOF : 8'($urandom);
          push(b, 1'b0);
          x ^= b;
        end
        if (kind == 2) x ^= 8'(1 << $urandom_range(0, 7));
        push(x, 1'b0);
      end
      3: begin
        push(SOF, 1'b0);
        push(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)), 1'b0);
      end
      4: begin
        pos = $urandom_range(0, len + 1);
        push(SOF, 1'b0);
        for (int i = 0; i <= pos; i++) begin
          b = (i == 0) ? 8'(len) : 8'($urandom);
          push(b, 1'(i == pos));
        end
      end
      5: begin
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
          push(8'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      default: push(SOF, 1'b1);
    endcase
  endtask

  initial begin
    PRESET     = 1'b1;
    RX_DATA    = 8'd0;
    RX_VALID   = 1'b0;
    RX_ERR     = 1'b0;
    OUT_READY  = 1'b0;
    ready_mode = 1;
    gap_pct    = 0;
    do_reset();

    // Basic good frame
    push(SOF, 0); push(8'h03, 0); push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h03, 0);
    run_until_idle(200);

    // Checksum error, then a good frame
    push(SOF, 0); push(8'h03, 0); push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h04, 0);
    push(SOF, 0); push(8'h02, 0); push(8'hA5, 0); push(8'h3C, 0); push(8'h9B, 0);
    run_until_idle(200);

    // Length errors with leading junk
    push(8'h55, 0); push(SOF, 0); push(8'h00, 0);
    push(SOF, 0); push(8'h11, 0);
    run_until_idle(200);

    // RX error mid-payload, then a one-byte frame
    push(SOF, 0); push(8'h02, 0); push(8'hAA, 0); push(8'hBB, 1);
    push(SOF, 0); push(8'h01, 0); push(8'h5A, 0); push(8'h5B, 0);
    run_until_idle(200);

    // Back-pressure with bytes arriving during drain
    ready_mode = 2;
    push(SOF, 0); push(8'h03, 0); push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h03, 0);
    push(SOF, 0); push(8'h01, 0); push(8'h5A, 0);
    repeat (19) cycle();
    ready_mode = 1;
    run_until_idle(200);

    // Reset in the middle of a drain
    ready_mode = 2;
    push(SOF, 0); push(8'h02, 0); push(8'hC3, 0); push(8'h3C, 0); push(8'hFD, 0);
    repeat (10) cycle();
    do_reset();
    ready_mode = 1;
    run_until_idle(50);

    // Stalled frame: times out with the option, waits forever without it
    push(SOF, 0); push(8'h02, 0); push(8'hAA, 0);
    repeat (3) cycle();
    repeat (1100) cycle();
    push(8'hBB, 0); push(8'h13, 0);
    run_until_idle(200);

    // Randomized traffic
    ready_mode = 0;
    gap_pct    = 30;
    for (int f = 0; f < 200; f++) begin
      gen_frame();
      if ($urandom_range(0, 3) != 0) run_until_idle(2000);
      else repeat ($urandom_range(0, 3)) cycle();
    end
    run_until_idle(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
